// File: rtl/pool_ctrl.sv
// pool_ctrl: sequencer for a KER_SIZE x KER_SIZE pooling layer over up to PAR_MAX
// parallel lanes. Each step reads KER_SIZE activation rows, waits one cycle for
// memory latency and writes one pooled row, with out_ready back-pressure.
// Optional feature: define POOL_CTRL_CYCLE_CNT_EN to build the busy-cycle counter;
// without it cycle_cnt is tied to zero.
module pool_ctrl #(
    parameter int KER_SIZE = 2,
    parameter int PAR_MAX  = 2,
    parameter int ADDR_W   = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [$clog2(PAR_MAX+1)-1:0]        cfg_par_num,
    input  logic [PAR_MAX-1:0][ADDR_W-1:0]      cfg_in_lo,
    input  logic [PAR_MAX-1:0][ADDR_W-1:0]      cfg_in_hi,
    input  logic [PAR_MAX-1:0][ADDR_W-1:0]      cfg_out_lo,
    output logic                                busy,
    output logic                                done,
    output logic                                act_rd_en,
    output logic [PAR_MAX-1:0][ADDR_W-1:0]      act_rd_addr,
    output logic [PAR_MAX-1:0]                  lane_en,
    output logic                                pool_clear,
    output logic                                pool_last,
    output logic                                out_wr_en,
    output logic [PAR_MAX-1:0][ADDR_W-1:0]      out_wr_addr,
    input  logic                                out_ready,
    output logic [15:0]                         cycle_cnt
);

    localparam int PN_W  = $clog2(PAR_MAX+1);
    localparam int CNT_W = ADDR_W + 1;               // a lane may span all 2^ADDR_W rows
    localparam int KW    = (KER_SIZE > 1) ? $clog2(KER_SIZE) : 1;
    localparam logic [CNT_W-1:0] KER_C  = CNT_W'(KER_SIZE);
    localparam logic [KW-1:0]    K_LAST = KW'(KER_SIZE - 1);
    localparam logic [PN_W-1:0]  PAR_C  = PN_W'(PAR_MAX);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                          state_r, state_s;
    logic [PN_W-1:0]                 par_num_s, par_num_r;
    logic [PAR_MAX-1:0][CNT_W-1:0]   steps_s, steps_r;
    logic [CNT_W-1:0]                total_s, total_r;
    logic [PAR_MAX-1:0][ADDR_W-1:0]  in_lo_r, out_lo_r;
    logic [CNT_W-1:0]                step_r, step_s;
    logic [KW-1:0]                   kidx_r, kidx_s;
    logic                            accept_s;

    assign accept_s = (state_r == ST_IDLE) && start;

    // Clamp the lane count and derive per-lane and overall step counts from the live cfg
    always_comb begin
        if (cfg_par_num == {PN_W{1'b0}}) begin
            par_num_s = PN_W'(1'b1);
        end else if (cfg_par_num > PAR_C) begin
            par_num_s = PAR_C;
        end else begin
            par_num_s = cfg_par_num;
        end
        total_s = {CNT_W{1'b0}};
        for (int i = 0; i < PAR_MAX; i++) begin
            if ((PN_W'(i) < par_num_s) && (cfg_in_hi[i] >= cfg_in_lo[i])) begin
                steps_s[i] = (CNT_W'(cfg_in_hi[i]) - CNT_W'(cfg_in_lo[i]) + CNT_W'(1'b1)) / KER_C;
            end else begin
                steps_s[i] = {CNT_W{1'b0}};
            end
            if (steps_s[i] > total_s) begin
                total_s = steps_s[i];
            end else begin
                total_s = total_s;
            end
        end
    end

    // Next-state and step/kernel-row counter logic
    always_comb begin
        state_s = state_r;
        step_s  = step_r;
        kidx_s  = kidx_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    step_s  = {CNT_W{1'b0}};
                    kidx_s  = {KW{1'b0}};
                    state_s = (total_s == {CNT_W{1'b0}}) ? ST_DONE : ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (kidx_r == K_LAST) begin
                    kidx_s  = {KW{1'b0}};
                    state_s = ST_WAIT;
                end else begin
                    kidx_s  = kidx_r + KW'(1'b1);
                end
            end
            ST_WAIT: begin
                state_s = ST_WRITE;
            end
            ST_WRITE: begin
                if (out_ready) begin
                    if (step_r == total_r - CNT_W'(1'b1)) begin
                        state_s = ST_DONE;
                    end else begin
                        step_s  = step_r + CNT_W'(1'b1);
                        state_s = ST_READ;
                    end
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and configuration registers; cfg is captured only on an accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            step_r    <= {CNT_W{1'b0}};
            kidx_r    <= {KW{1'b0}};
            par_num_r <= {PN_W{1'b0}};
            steps_r   <= '0;
            total_r   <= {CNT_W{1'b0}};
            in_lo_r   <= '0;
            out_lo_r  <= '0;
        end else begin
            state_r <= state_s;
            step_r  <= step_s;
            kidx_r  <= kidx_s;
            if (accept_s) begin
                par_num_r <= par_num_s;
                steps_r   <= steps_s;
                total_r   <= total_s;
                in_lo_r   <= cfg_in_lo;
                out_lo_r  <= cfg_out_lo;
            end else begin
                par_num_r <= par_num_r;
                steps_r   <= steps_r;
                total_r   <= total_r;
                in_lo_r   <= in_lo_r;
                out_lo_r  <= out_lo_r;
            end
        end
    end

    // Outputs decode from registered state only; rst forces them low even before the clock edge
    always_comb begin
        busy        = !rst && (state_r != ST_IDLE);
        done        = !rst && (state_r == ST_DONE);
        act_rd_en   = !rst && (state_r == ST_READ);
        out_wr_en   = !rst && (state_r == ST_WRITE);
        pool_clear  = act_rd_en && (kidx_r == {KW{1'b0}});
        pool_last   = act_rd_en && (kidx_r == K_LAST);
        lane_en     = '0;
        act_rd_addr = '0;
        out_wr_addr = '0;
        for (int i = 0; i < PAR_MAX; i++) begin
            lane_en[i] = (act_rd_en || out_wr_en) && (PN_W'(i) < par_num_r) && (step_r < steps_r[i]);
            if (act_rd_en && lane_en[i]) begin
                act_rd_addr[i] = in_lo_r[i] + ADDR_W'(step_r * KER_C) + ADDR_W'(kidx_r);
            end else begin
                act_rd_addr[i] = {ADDR_W{1'b0}};
            end
            if (out_wr_en && lane_en[i]) begin
                out_wr_addr[i] = out_lo_r[i] + ADDR_W'(step_r);
            end else begin
                out_wr_addr[i] = {ADDR_W{1'b0}};
            end
        end
    end

`ifdef POOL_CTRL_CYCLE_CNT_EN
    logic [15:0] cyc_r;

    // Busy-cycle counter: restarts on accepted start, saturates, holds once back in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_r <= 16'h0000;
        end else if (accept_s) begin
            cyc_r <= 16'h0000;
        end else if ((state_r != ST_IDLE) && (cyc_r != 16'hFFFF)) begin
            cyc_r <= cyc_r + 16'h0001;
        end else begin
            cyc_r <= cyc_r;
        end
    end

    assign cycle_cnt = rst ? 16'h0000 : cyc_r;
`else
    assign cycle_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pool_ctrl.sv
// Scoreboard bench for pool_ctrl: each layer's expected reads, writes and done pulse
// are queued at stimulus time; a negedge monitor pops and compares as the DUT emits them.
module tb_pool_ctrl;

    localparam int KER = 2;
    localparam int PM  = 2;
    localparam int AW  = 5;
`ifdef POOL_CTRL_CYCLE_CNT_EN
    localparam logic [15:0] EXP_CYC = 16'd57;
`else
    localparam logic [15:0] EXP_CYC = 16'd0;
`endif

    logic                    clk = 1'b0;
    logic                    rst, start, out_ready;
    logic [1:0]              cfg_par_num;
    logic [PM-1:0][AW-1:0]   cfg_in_lo, cfg_in_hi, cfg_out_lo;
    logic                    busy, done, act_rd_en, pool_clear, pool_last, out_wr_en;
    logic [PM-1:0][AW-1:0]   act_rd_addr, out_wr_addr;
    logic [PM-1:0]           lane_en;
    logic [15:0]             cycle_cnt;

    always #5 clk = ~clk;

    pool_ctrl #(.KER_SIZE(KER), .PAR_MAX(PM), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_par_num(cfg_par_num),
        .cfg_in_lo(cfg_in_lo), .cfg_in_hi(cfg_in_hi), .cfg_out_lo(cfg_out_lo),
        .busy(busy), .done(done), .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr),
        .lane_en(lane_en), .pool_clear(pool_clear), .pool_last(pool_last),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_ready(out_ready),
        .cycle_cnt(cycle_cnt)
    );

    typedef struct {
        logic [PM-1:0][AW-1:0] addr;
        logic [PM-1:0]         en;
        logic                  clr;
        logic                  lst;
    } rd_t;
    typedef struct {
        logic [PM-1:0][AW-1:0] addr;
        logic [PM-1:0]         en;
    } wr_t;

    rd_t rd_q[$];
    wr_t wr_q[$];
    int  done_q   = 0;
    int  checks   = 0;
    int  errors   = 0;
    int  rd_cnt   = 0;
    int  wr_cnt   = 0;
    int  wr1_cnt  = 0;
    int  done_cnt = 0;
    rd_t mon_rd;
    wr_t mon_wr;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic void unexpected(string name);
        checks++;
        errors++;
        $display("FAIL %s actual=present required=absent", name);
    endfunction

    // Monitor: compare every read, accepted write and done pulse against the queues
    always @(negedge clk) begin
        if (!rst) begin
            if (act_rd_en) begin
                rd_cnt++;
                if (rd_q.size() == 0) begin
                    unexpected("rd_extra");
                end else begin
                    mon_rd = rd_q.pop_front();
                    chk("rd_addr", act_rd_addr, mon_rd.addr);
                    chk("rd_lane_en", lane_en, mon_rd.en);
                    chk("pool_clear", pool_clear, mon_rd.clr);
                    chk("pool_last", pool_last, mon_rd.lst);
                end
            end
            if (out_wr_en && out_ready) begin
                wr_cnt++;
                if (lane_en[1]) wr1_cnt++;
                if (wr_q.size() == 0) begin
                    unexpected("wr_extra");
                end else begin
                    mon_wr = wr_q.pop_front();
                    chk("wr_addr", out_wr_addr, mon_wr.addr);
                    chk("wr_lane_en", lane_en, mon_wr.en);
                end
            end
            if (done) begin
                done_cnt++;
                if (done_q == 0) begin
                    unexpected("done_extra");
                end else begin
                    done_q--;
                end
            end
        end
    end

    // Reference model: queue everything one layer should produce from the current cfg
    task automatic expect_layer();
        int p, s_max;
        int st[PM];
        rd_t r;
        wr_t w;
        p = (cfg_par_num == 2'd0) ? 1 : ((int'(cfg_par_num) > PM) ? PM : int'(cfg_par_num));
        s_max = 0;
        for (int i = 0; i < PM; i++) begin
            st[i] = (i < p && cfg_in_hi[i] >= cfg_in_lo[i]) ?
                    (int'(cfg_in_hi[i]) - int'(cfg_in_lo[i]) + 1) / KER : 0;
            if (st[i] > s_max) s_max = st[i];
        end
        for (int s = 0; s < s_max; s++) begin
            for (int k = 0; k < KER; k++) begin
                for (int i = 0; i < PM; i++) begin
                    r.en[i]   = (s < st[i]);
                    r.addr[i] = r.en[i] ? AW'(int'(cfg_in_lo[i]) + s * KER + k) : '0;
                end
                r.clr = (k == 0);
                r.lst = (k == KER - 1);
                rd_q.push_back(r);
            end
            for (int i = 0; i < PM; i++) begin
                w.en[i]   = (s < st[i]);
                w.addr[i] = w.en[i] ? AW'(int'(cfg_out_lo[i]) + s) : '0;
            end
            wr_q.push_back(w);
        end
        done_q++;
    endtask

    task automatic set_cfg(input int par, input int l0, input int h0, input int l1,
                           input int h1, input int o0, input int o1);
        cfg_par_num   = 2'(par);
        cfg_in_lo[0]  = AW'(l0);
        cfg_in_hi[0]  = AW'(h0);
        cfg_in_lo[1]  = AW'(l1);
        cfg_in_hi[1]  = AW'(h1);
        cfg_out_lo[0] = AW'(o0);
        cfg_out_lo[1] = AW'(o1);
        rd_cnt  = 0;
        wr_cnt  = 0;
        wr1_cnt = 0;
    endtask

    // Called #1 after a posedge; returns #1 after the posedge that accepts start
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=busy required=idle", name);
        end
    endtask

    task automatic end_check(input string name);
        chk({name, "_rd_left"}, rd_q.size(), 0);
        chk({name, "_wr_left"}, wr_q.size(), 0);
        chk({name, "_done_left"}, done_q, 0);
    endtask

    task automatic check_zero(input string name);
        chk(name, {busy, done, act_rd_en, pool_clear, pool_last, out_wr_en, lane_en,
                   act_rd_addr, out_wr_addr, cycle_cnt}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_snap;
        logic [PM-1:0][AW-1:0] wa;
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_zero("reset_outputs");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero("idle_outputs");

        // One lane, rows 0..27: 28 reads, 14 writes, 57 busy cycles
        set_cfg(1, 0, 27, 0, 0, 0, 0);
        expect_layer();
        pulse_start();
        wait_idle("t1", 200);
        end_check("t1");
        chk("t1_reads", rd_cnt, 28);
        chk("t1_writes", wr_cnt, 14);
        chk("t1_cycle_cnt", cycle_cnt, EXP_CYC);
        @(posedge clk); #1;
        chk("t1_cycle_cnt_hold", cycle_cnt, EXP_CYC);

        // Two full lanes
        set_cfg(2, 0, 9, 10, 19, 0, 5);
        expect_layer();
        pulse_start();
        wait_idle("t2", 100);
        end_check("t2");
        chk("t2_writes", wr_cnt, 5);
        chk("t2_lane1_writes", wr1_cnt, 5);

        // Lane 1 runs out after 3 steps
        set_cfg(2, 0, 9, 10, 15, 0, 5);
        expect_layer();
        pulse_start();
        wait_idle("t3", 100);
        end_check("t3");
        chk("t3_lane1_writes", wr1_cnt, 3);

        // Back-pressure: out_ready low for the first 3 write cycles
        set_cfg(1, 0, 3, 0, 0, 0, 0);
        out_ready = 1'b0;
        expect_layer();
        pulse_start();
        for (int n = 0; n < 20 && !out_wr_en; n++) @(negedge clk);
        chk("t4_wr_seen", out_wr_en, 1'b1);
        wa = out_wr_addr;
        rd_snap = rd_cnt;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (c == 2) out_ready = 1'b1;
            @(negedge clk);
            chk("t4_wr_hold", out_wr_en, 1'b1);
            chk("t4_addr_hold", out_wr_addr, wa);
        end
        chk("t4_no_extra_reads", rd_cnt, rd_snap);
        chk("t4_reads_before_accept", rd_cnt, 2);
        @(posedge clk); #1;
        wait_idle("t4", 100);
        end_check("t4");
        chk("t4_writes", wr_cnt, 2);

        // Repeated start ignored, then rst in step 2 aborts without done
        set_cfg(1, 0, 27, 0, 0, 0, 0);
        expect_layer();
        pulse_start();
        repeat (2) begin @(posedge clk); #1; end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        check_zero("t5_rst_outputs");
        chk("t5_reads_before_rst", rd_cnt, 5);
        chk("t5_writes_before_rst", wr_cnt, 2);
        rd_q.delete();
        wr_q.delete();
        done_q = 0;
        rd_snap = done_cnt;
        @(posedge clk); #1;
        chk("t5_no_done", done_cnt, rd_snap);
        set_cfg(1, 0, 27, 0, 0, 0, 0);
        expect_layer();
        rst = 1'b0;
        pulse_start();
        wait_idle("t5", 200);
        end_check("t5");
        chk("t5_reads_after", rd_cnt, 28);
        chk("t5_done_count", done_cnt, rd_snap + 1);

        // Empty ranges: straight to DONE, no reads or writes
        set_cfg(2, 5, 4, 20, 3, 0, 0);
        expect_layer();
        pulse_start();
        @(negedge clk);
        chk("t6_done", done, 1'b1);
        chk("t6_busy", busy, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_done_clear", done, 1'b0);
        chk("t6_idle", busy, 1'b0);
        @(posedge clk); #1;
        end_check("t6");
        chk("t6_reads", rd_cnt, 0);
        chk("t6_writes", wr_cnt, 0);

        // cfg_par_num 0 acts as 1 lane; lane 1 stays off
        set_cfg(0, 0, 3, 0, 5, 0, 0);
        expect_layer();
        pulse_start();
        wait_idle("t7", 100);
        end_check("t7");
        chk("t7_lane1_writes", wr1_cnt, 0);

        // cfg_par_num 3 clamps to 2 lanes
        set_cfg(3, 0, 3, 8, 11, 0, 4);
        expect_layer();
        pulse_start();
        wait_idle("t8", 100);
        end_check("t8");
        chk("t8_lane1_writes", wr1_cnt, 2);

        // Address wrap: reads 28..31, writes 31 then 0
        set_cfg(1, 28, 31, 0, 0, 31, 0);
        expect_layer();
        pulse_start();
        wait_idle("t9", 100);
        end_check("t9");
        chk("t9_writes", wr_cnt, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
